alu_rr_scheduler: RTL
=====================

// Module: alu_rr_scheduler
// PURPOSE
//  Shares one N-bit ALU (add/sub/and/or) between NREQ requesters.
//  Round-robin arbitration; valid/ready on each request port and on the response port.
//  One-entry registered result buffer; each response is tagged with the winner's index.
//  Sits between client engines and the shared ALU datapath.
// PARAMETERS
//  N     8  operand/result width
//  NREQ  4  number of requesters (2..8); IDW = $clog2(NREQ)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        async reset, active-high
//  req_valid    in   NREQ     bit i: requester i presents an op
//  req_ready    out  NREQ     bit i: op i accepted this cycle (one-hot or 0)
//  req_opcode   in   3*NREQ   slice i = [3i+2:3i]
//  req_a        in   N*NREQ   slice i = [N*i+N-1:N*i]
//  req_b        in   N*NREQ   same slicing as req_a
//  rsp_valid    out  1        result buffer holds a response
//  rsp_ready    in   1        consumer takes the response
//  rsp_id       out  IDW      index of the requester that owns rsp_result
//  rsp_result   out  N        ALU result
//  rsp_err      out  1        1 = opcode was illegal
// BEHAVIOUR
//  Reset (async): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, state=EMPTY, rr_ptr=NREQ-1.
//  Opcodes: 000 a+b; 001 a-b; 010 a&b; 011 a|b; all mod 2^N, carry/borrow dropped.
//   1xx: illegal -> rsp_result=0, rsp_err=1. The response is still returned (never dropped).
//  FSM: EMPTY (buffer free), FULL (buffer holds a response).
//   can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
//   EMPTY: a grant this cycle -> FULL.
//   FULL: rsp_ready & no grant -> EMPTY; rsp_ready & grant -> stays FULL with the new data.
//   FULL with !rsp_ready: hold rsp_* stable; req_ready=0.
//  Arbitration: combinational. Search req_valid starting at index rr_ptr+1 (mod NREQ).
//   The first set bit wins, and req_ready[win]=1 only if can_accept.
//   rr_ptr <= win only on an actual grant (valid & ready).
//  Latency: op granted at edge k -> rsp_valid=1 with its result after edge k (1 cycle).
//   With rsp_ready held high, throughput is 1 op/clk.
//  Requesters must hold valid/opcode/a/b stable until ready. req_ready never depends on
//   a requester's own valid being held, except through the search.
//  No valid requests -> req_ready=0 and rr_ptr unchanged.
//  Single active requester -> it is granted every cycle the buffer allows.
//  Reset mid-operation: the buffered response is discarded, with no partial output.
// CONFIGURATION
//  ALU_RR_FLAGS_EN defined:
//   Adds outputs rsp_zero (result==0) and rsp_carry.
//   rsp_carry = carry-out for add, borrow (a<b) for sub, 0 for and/or/illegal.
//   Both are registered with rsp_result, reset to 0, and held while FULL & !rsp_ready.
//  ALU_RR_FLAGS_EN undefined: these ports and their registers do not exist.
// TESTING (N=8, NREQ=4)
//  After reset, req 2 only, op 000, a=0xF0, b=0x20 -> req_ready=0100.
//   Next cycle: rsp_valid=1, rsp_id=2, rsp_result=0x10, rsp_err=0 (flags on: zero=0, carry=1).
//  All 4 valid, rsp_ready=1, 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_id follows one cycle later.
//  rsp_ready=0 with FULL for 3 cycles, all reqs valid -> req_ready=0000 and rsp_* stable.
//   Then rsp_ready=1 -> the next rr winner is granted in the same cycle.
//  op 101 from req 1, a=0x33, b=0x11 -> rsp_result=0x00, rsp_err=1, rsp_id=1.
//   Then op 001 a=0x05, b=0x07 -> result=0xFE (flags on: carry=1).
//  rst pulsed for half a cycle while FULL -> rsp_valid=0 immediately.
//   Afterwards, with req 3 and req 0 valid -> req 0 is granted first (rr_ptr=3).

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one add/sub/and/or ALU between NREQ requesters,
// with a one-entry tagged result buffer. Define ALU_RR_FLAGS_EN for rsp_zero/rsp_carry.
module alu_rr_scheduler #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_opcode,
  input  logic [N*NREQ-1:0] req_a,
  input  logic [N*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_err
`ifdef ALU_RR_FLAGS_EN
  ,
  output logic              rsp_zero,
  output logic              rsp_carry
`endif
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]     state;
  logic [0:0]     state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic           can_accept;
  logic           grant;
  logic [2:0]     op;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [N:0]     alu_ext;
  logic           alu_err;

  assign rsp_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) | (rsp_valid & rsp_ready);
  assign grant      = found & can_accept;

  // Round-robin search starting one past the last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(32'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((32'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  assign op   = req_opcode[32'(win) * 3 +: 3];
  assign op_a = req_a[32'(win) * N +: N];
  assign op_b = req_b[32'(win) * N +: N];

  // Extra top bit carries add carry-out / sub borrow
  always_comb begin
    alu_ext = '0;
    alu_err = 1'b0;
    case (op)
      3'b000:  alu_ext = {1'b0, op_a} + {1'b0, op_b};
      3'b001:  alu_ext = {1'b0, op_a} - {1'b0, op_b};
      3'b010:  alu_ext = {1'b0, op_a & op_b};
      3'b011:  alu_ext = {1'b0, op_a | op_b};
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (rsp_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Buffer only loads on a grant, so a stalled response stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= IDW'(NREQ - 1);
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else if (grant) begin
      rr_ptr     <= win;
      rsp_id     <= win;
      rsp_result <= alu_ext[N-1:0];
      rsp_err    <= alu_err;
    end
  end

`ifdef ALU_RR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
    end else if (grant) begin
      rsp_zero  <= (alu_ext[N-1:0] == '0);
      rsp_carry <= alu_ext[N];
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_ext[N];
`endif

endmodule
